// File: rtl/bcd_to_bin_pkg.sv
// Shared constants and state encoding for the BCD to binary converter.
package bcd_to_bin_pkg;

  localparam int BCD_DIGITS    = 3;
  localparam int BIN_W         = 10;
  localparam int CONV_CYCLES   = 10;
  localparam int BCD_MAX_DIGIT = 9;
  localparam int CNT_W         = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/bcd_to_bin_digit_adjust.sv
// Reverse double-dabble digit correction: a nibble of 8 or more loses 3.
module bcd_digit_adjust (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = din[3] ? (din - 4'd3) : din;

endmodule

// File: rtl/bcd_to_bin.sv
// Iterative 3-digit BCD to binary converter, one result bit per clock.
module bcd_to_bin
  import bcd_to_bin_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       centenas,
  input  logic [3:0]       decenas,
  input  logic [3:0]       unidades,
  output logic [BIN_W-1:0] numBin,
  output logic             busy,
  output logic             done,
  output logic             error
);

  state_t                    state, state_nx;
  logic [4*BCD_DIGITS-1:0]   bcd_r, bcd_sh, bcd_adj;
  logic [BIN_W-1:0]          bin_r, bin_sh;
  logic [CNT_W-1:0]          cnt;
  logic                      err_r;
  logic                      digit_bad;
  logic                      last_shift;

  assign bcd_sh = bcd_r >> 1;
  assign bin_sh = {bcd_r[0], bin_r[BIN_W-1:1]};

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .din  (bcd_sh[4*g +: 4]),
      .dout (bcd_adj[4*g +: 4])
    );
  end

  assign digit_bad  = (centenas > 4'(BCD_MAX_DIGIT)) ||
                      (decenas  > 4'(BCD_MAX_DIGIT)) ||
                      (unidades > 4'(BCD_MAX_DIGIT));
  assign last_shift = (cnt == CNT_W'(CONV_CYCLES - 1));

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_SHIFT;
      ST_SHIFT: if (last_shift) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      bcd_r  <= '0;
      bin_r  <= '0;
      cnt    <= '0;
      err_r  <= 1'b0;
      numBin <= '0;
      error  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: begin
          if (start) begin
            bcd_r <= {centenas, decenas, unidades};
            bin_r <= '0;
            cnt   <= '0;
            err_r <= digit_bad;
          end
        end
        ST_SHIFT: begin
          bcd_r <= bcd_adj;
          bin_r <= bin_sh;
          cnt   <= cnt + CNT_W'(1);
          // Results are registered on the edge into DONE so they are valid with done.
          if (last_shift) begin
            numBin <= err_r ? '0 : bin_sh;
            error  <= err_r;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Randomized self-checking bench for bcd_to_bin against a decimal reference model.
module tb_bcd_to_bin;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] centenas = '0, decenas = '0, unidades = '0;
  logic [9:0] numBin;
  logic       busy, done, error;

  int checks = 0;
  int errors = 0;

  bcd_to_bin dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .centenas (centenas),
    .decenas  (decenas),
    .unidades (unidades),
    .numBin   (numBin),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_val(input int c, input int d, input int u);
    if (c > 9 || d > 9 || u > 9) return 0;
    return c * 100 + d * 10 + u;
  endfunction

  function automatic bit model_err(input int c, input int d, input int u);
    return (c > 9 || d > 9 || u > 9);
  endfunction

  // Starts one conversion, scrambles the inputs in flight, returns in the following IDLE cycle.
  task automatic convert(input int c, input int d, input int u, input string tag);
    int n;
    bit busy_ok;
    busy_ok = 1'b1;
    @(negedge clk);
    centenas = 4'(c); decenas = 4'(d); unidades = 4'(u); start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    centenas = 4'($urandom); decenas = 4'($urandom); unidades = 4'($urandom);
    n = 1;
    while (!done && n < 20) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, n, 11);
    check({tag, " busy"}, {31'd0, busy_ok & busy}, 1);
    check({tag, " numBin"}, numBin, model_val(c, d, u));
    check({tag, " error"}, error, model_err(c, d, u));
    @(negedge clk);
    check({tag, " idle busy"}, busy, 0);
  endtask

  initial begin
    int done_cnt;
    bit sweep_ok;
    logic [9:0] held;

    repeat (3) @(negedge clk);
    check("reset numBin", numBin, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset error", error, 0);
    reset = 1'b0;

    convert(9, 9, 9, "999");
    convert(0, 0, 0, "000");
    convert(5, 1, 2, "512");

    held = numBin;
    start = 1'b0;
    repeat (6) begin
      centenas = 4'($urandom); decenas = 4'($urandom); unidades = 4'($urandom);
      @(negedge clk);
    end
    check("hold numBin", numBin, {22'd0, held});
    check("hold error", error, 0);

    convert(1, 2, 3, "123");
    convert(1, 10, 3, "1A3");
    convert(0, 4, 2, "042");
    convert(15, 0, 0, "F00");

    for (int i = 0; i < 20; i++) begin
      int c, d, u;
      c = $urandom_range(15); d = $urandom_range(15); u = $urandom_range(15);
      convert(c, d, u, "rand");
    end

    // start held high: one conversion every 12 cycles
    done_cnt = 0;
    for (int k = 0; k < 36; k++) begin
      start = 1'b1;
      if (k % 12 == 0) begin
        centenas = 4'd2; decenas = 4'd5; unidades = 4'd5;
      end else begin
        centenas = 4'($urandom); decenas = 4'($urandom); unidades = 4'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        done_cnt++;
        check("held phase", (k + 1) % 12, 11);
        check("held numBin", numBin, 255);
        check("held error", error, 0);
      end
    end
    start = 1'b0;
    check("held count", done_cnt, 3);
    @(negedge clk);

    // reset mid-conversion
    centenas = 4'd7; decenas = 4'd7; unidades = 4'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("abort numBin", numBin, 0);
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort error", error, 0);
    done_cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("abort no done", done_cnt, 0);
    convert(3, 0, 0, "300");

    sweep_ok = 1'b1;
    for (int v = 0; v < 1000; v++) begin
      int c, d, u, n;
      c = v / 100; d = (v / 10) % 10; u = v % 10;
      @(negedge clk);
      centenas = 4'(c); decenas = 4'(d); unidades = 4'(u); start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      n = 1;
      while (!done && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (n != 11 || numBin != 10'(v) || error) begin
        if (sweep_ok)
          check("sweep", {12'd0, numBin, 9'd0, error}, {12'd0, 10'(v), 10'd0});
        sweep_ok = 1'b0;
      end
    end
    check("sweep all", {31'd0, sweep_ok}, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin.md
Name: bcd_to_bin

Overview:
Sequential 3-digit BCD to 10-bit binary converter using reverse double-dabble: shift right, then subtract 3 from any digit that is 8 or more.
- Converts score, level and timer values entered or stored as decimal digits back to binary for arithmetic and comparison.
- Sits beside the binary-to-BCD display converter in the game datapath.
- Iterative: one bit per clock, with a start/busy/done handshake.

Parameters:
- DIGITS, 3, number of BCD input digits (centenas, decenas, unidades); fixed at 3 in this revision.
- BIN_W, 10, width of the binary result; covers 0..999.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a conversion; sampled only in IDLE.
- centenas  input  4  hundreds digit, BCD.
- decenas  input  4  tens digit, BCD.
- unidades  input  4  units digit, BCD.
- numBin  output  10  binary result; held until the next accepted start.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when numBin and error are valid.
- error  output  1  high with done if any input digit was greater than 9; held like numBin.

Behaviour:
- Reset (synchronous, active-high, dominates everything): state=IDLE, numBin=0, busy=0, done=0, error=0, internal registers=0.
- Reset asserted mid-conversion aborts it; no done pulse follows.
- States:
  - IDLE: if start=1, capture the digits into a 12-bit shift register bcd_r, clear the 10-bit bin_r, set cnt=0, latch err_r = (any digit > 9), then go to SHIFT.
  - SHIFT: each cycle, shift {bcd_r, bin_r} right by 1 as a 22-bit value. Then, for each 4-bit nibble of the shifted bcd_r, if the nibble is 8 or more, subtract 3 (this adjust is combinational, in the same cycle). cnt increments. When cnt reaches BIN_W-1 on this cycle, go to DONE.
  - DONE: numBin <= err_r ? 0 : bin_r; error <= err_r; done=1 for exactly this cycle; then go to IDLE.
- Latency: start sampled in cycle 0; SHIFT occupies cycles 1..10; done=1 in cycle 11. Back-to-back rate is one conversion per 12 cycles.
- busy=1 in SHIFT and DONE only.
- start while not in IDLE is ignored; there is no queueing.
- Input digits may change after the start cycle without affecting the result.
- Invalid digits (A..F) still run all 10 shift cycles, so latency is constant; the result is forced to 0 and error=1.
- Arithmetic: all internal values are unsigned. The subtract-3 never underflows because it only applies to nibbles of 8 or more. The maximum valid result is 999 (10'h3E7), so there is no overflow.
- numBin and error update only in DONE and are stable in between.

Decomposition:
- Shared package/include holds:
  - BCD_DIGITS=3, BIN_W=10, CONV_CYCLES=10.
  - State encodings ST_IDLE, ST_SHIFT, ST_DONE.
  - BCD_MAX_DIGIT=9.
- One natural sub-module: bcd_digit_adjust.
  - Combinational; 4-bit in, 4-bit out: out = (in >= 8) ? in - 3 : in.
  - Instantiated DIGITS times.
- The top level holds the FSM, counter, shift register and output registers.

Test Plan:
- Reset then start with 9,9,9 -> done exactly 11 cycles after the start cycle; numBin=999, error=0; busy high for cycles 1..11.
- Digits 0,0,0 -> numBin=0. Then digits 5,1,2 -> numBin=512. Then 1,2,3 -> numBin=123. The outputs hold between done pulses.
- Digits 1,A,3 -> done after 11 cycles with numBin=0 and error=1. A following conversion of 0,4,2 -> numBin=42, error=0.
- start held high continuously with 2,5,5 -> one conversion every 12 cycles, each giving numBin=255. Changing the digits during SHIFT does not alter the result in flight.
- Start conversion 7,7,7, then assert reset in cycle 5 -> all outputs 0 the next cycle, no done pulse, and the next start (3,0,0) gives numBin=300.
- Exhaustive sweep of 0..999 (BCD in) -> numBin equals the decimal value every time, and error is never set.
